// File: rtl/pulse_timestamper.sv
`default_nettype none
// ============================================================================
// Module  : pulse_timestamper - per-channel edge/deadtime hit tagger feeding an
//           FWFT event FIFO drained over valid/ready.      Revision: 1.0
// ============================================================================
module pulse_timestamper #(
  parameter int NCH      = 2,
  parameter int TS_WIDTH = 32,
  parameter int DEADTIME = 16,
  parameter int FIFO_AW  = 4
) (
  input  logic                    CLK_FAST,
  input  logic                    RESET_FAST,
  input  logic [NCH-1:0]          PULSE_IN,
  input  logic                    ENABLE,
  output logic [NCH+TS_WIDTH-1:0] EV_DATA,
  output logic                    EV_VALID,
  input  logic                    EV_READY,
  output logic [FIFO_AW:0]        FIFO_LEVEL,
  output logic [15:0]             DROP_COUNT
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int DW    = NCH + TS_WIDTH;
  localparam int DTW   = $clog2(DEADTIME + 1);
  localparam logic [DTW-1:0]   DEAD_LOAD = DTW'(DEADTIME);
  localparam logic [DTW-1:0]   DEAD_ONE  = DTW'(1);
  localparam logic [FIFO_AW:0] PTR_ZERO  = '0;

  logic [NCH-1:0]      sync1, sync2, prev;
  logic [NCH-1:0]      rise, hit;
  logic [1:0]          arm_cnt;
  logic                armed;
  logic [TS_WIDTH-1:0] ts;
  logic [DTW-1:0]      dead [NCH];

  logic [DW-1:0]       mem [DEPTH];
  logic [FIFO_AW:0]    wr_ptr, rd_ptr, wr_next, rd_next;
  logic                full, push, pop, any_hit, valid_next;
  logic [DW-1:0]       word, head_next;

  assign rise  = sync2 & ~prev;
  assign armed = (arm_cnt == 2'd3);

  always_comb begin
    hit = '0;
    for (int i = 0; i < NCH; i++) begin
      hit[i] = rise[i] & armed & (dead[i] == '0);
    end
  end

  always_ff @(posedge CLK_FAST) begin
    if (!RESET_FAST) begin
      sync1   <= '0;
      sync2   <= '0;
      prev    <= '0;
      arm_cnt <= 2'd0;
      ts      <= '0;
      for (int i = 0; i < NCH; i++) dead[i] <= '0;
    end else begin
      sync1 <= PULSE_IN;
      sync2 <= sync1;
      prev  <= sync2;
      ts    <= ts + TS_WIDTH'(1);
      if (!armed) arm_cnt <= arm_cnt + 2'd1;
      for (int i = 0; i < NCH; i++) begin
        if (hit[i])             dead[i] <= DEAD_LOAD;
        else if (dead[i] != '0) dead[i] <= dead[i] - DEAD_ONE;
      end
    end
  end

  // Full/empty come from the extra pointer MSB; the write decision uses the
  // pre-pop occupancy, so a full FIFO refuses even when popping this cycle.
  assign any_hit = |hit;
  assign word    = {hit, ts};
  assign full    = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                   (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign push    = ENABLE & any_hit & ~full;
  assign pop     = EV_VALID & EV_READY;
  assign wr_next = wr_ptr + {PTR_ZERO[FIFO_AW:1], push};
  assign rd_next = rd_ptr + {PTR_ZERO[FIFO_AW:1], pop};
  assign valid_next = (wr_next != rd_next);
  assign FIFO_LEVEL = wr_ptr - rd_ptr;

  // The registered head is the word at the post-update read pointer; when that
  // slot is being written on this same edge, bypass the memory.
  assign head_next = (push && (rd_next == wr_ptr)) ? word
                                                   : mem[rd_next[FIFO_AW-1:0]];

  always_ff @(posedge CLK_FAST) begin
    if (push) mem[wr_ptr[FIFO_AW-1:0]] <= word;
  end

  always_ff @(posedge CLK_FAST) begin
    if (!RESET_FAST) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      EV_VALID   <= 1'b0;
      EV_DATA    <= '0;
      DROP_COUNT <= '0;
    end else begin
      wr_ptr   <= wr_next;
      rd_ptr   <= rd_next;
      EV_VALID <= valid_next;
      EV_DATA  <= valid_next ? head_next : '0;
      if (ENABLE && any_hit && full && (DROP_COUNT != 16'hFFFF)) begin
        DROP_COUNT <= DROP_COUNT + 16'd1;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_pulse_timestamper.sv
`default_nettype none
// ============================================================================
// Module  : tb_pulse_timestamper - directed and random checks of
//           pulse_timestamper against a cycle-level event model. Revision: 1.0
// ============================================================================
module tb_pulse_timestamper;
  localparam int NCH = 2, DEAD = 16, DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  pin = 2'b00;
  logic        en = 1'b0;
  logic        ready = 1'b0;
  logic [33:0] ev_data;
  logic        ev_valid;
  logic [4:0]  level;
  logic [15:0] drops;
  logic [9:0]  ev_data8;
  logic        ev_valid8;
  logic [4:0]  level8;
  logic [15:0] drops8;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [1:0]  mask;
    logic [31:0] t;
  } ev_t;

  ev_t        q[$];
  logic [1:0] hist[$];
  int         cyc;
  int         last_hit[NCH];
  int         mdrop;

  pulse_timestamper #(.NCH(2), .TS_WIDTH(32), .DEADTIME(16), .FIFO_AW(4)) dut (
    .CLK_FAST(clk), .RESET_FAST(rst_n), .PULSE_IN(pin), .ENABLE(en),
    .EV_DATA(ev_data), .EV_VALID(ev_valid), .EV_READY(ready),
    .FIFO_LEVEL(level), .DROP_COUNT(drops));

  pulse_timestamper #(.NCH(2), .TS_WIDTH(8), .DEADTIME(16), .FIFO_AW(4)) dut8 (
    .CLK_FAST(clk), .RESET_FAST(rst_n), .PULSE_IN(pin), .ENABLE(en),
    .EV_DATA(ev_data8), .EV_VALID(ev_valid8), .EV_READY(ready),
    .FIFO_LEVEL(level8), .DROP_COUNT(drops8));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    q.delete();
    hist.delete();
    for (int k = 0; k < 3; k++) hist.push_back(2'b00);
    cyc   = 0;
    mdrop = 0;
    for (int i = 0; i < NCH; i++) last_hit[i] = -1000;
  endtask

  // One clock edge of the model: hist[0] is the pin sample one edge ago,
  // so a rise seen in cycle c compares samples from edges c-2 and c-3.
  task automatic model_edge();
    logic [1:0] h;
    logic       do_push, do_pop;
    ev_t        e;
    if (!rst_n) begin
      model_reset();
    end else begin
      h = 2'b00;
      for (int i = 0; i < NCH; i++) begin
        if (hist[1][i] && !hist[2][i] && cyc >= 3 && (cyc - last_hit[i]) > DEAD) begin
          h[i] = 1'b1;
          last_hit[i] = cyc;
        end
      end
      do_pop  = (q.size() != 0) && ready;
      do_push = 1'b0;
      if (h != 2'b00 && en) begin
        if (q.size() < DEPTH) do_push = 1'b1;
        else if (mdrop < 65535) mdrop++;
      end
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        e.mask = h;
        e.t    = 32'(cyc);
        q.push_back(e);
      end
      hist.push_front(pin);
      void'(hist.pop_back());
      cyc++;
    end
  endtask

  task automatic compare_outputs();
    chk("valid", {63'd0, ev_valid}, {63'd0, q.size() != 0});
    chk("level", {59'd0, level}, 64'(q.size()));
    chk("drops", {48'd0, drops}, 64'(mdrop));
    chk("valid8", {63'd0, ev_valid8}, {63'd0, q.size() != 0});
    chk("level8", {59'd0, level8}, 64'(q.size()));
    if (q.size() != 0) begin
      chk("data", {30'd0, ev_data}, {30'd0, q[0].mask, q[0].t});
      chk("data8", {54'd0, ev_data8}, {54'd0, q[0].mask, q[0].t[7:0]});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_outputs();
  endtask

  task automatic run_to(input int c);
    for (int k = 0; k < 20000 && cyc < c; k++) tick();
  endtask

  // Pin high for exactly one sample: the hit lands two cycles later.
  task automatic pulse(input logic [1:0] m);
    pin = m;
    tick();
    pin = 2'b00;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int          base;
    logic [31:0] tsv[3];
    model_reset();
    en = 1'b1;

    // T1: single rise, latency and word contents
    do_reset();
    chk("rst_valid", {63'd0, ev_valid}, 64'd0);
    chk("rst_level", {59'd0, level}, 64'd0);
    chk("rst_drops", {48'd0, drops}, 64'd0);
    run_to(100);
    pulse(2'b01);
    tick();
    chk("t1_valid_early", {63'd0, ev_valid}, 64'd0);
    tick();
    chk("t1_valid", {63'd0, ev_valid}, 64'd1);
    chk("t1_data", {30'd0, ev_data}, {30'd0, 2'b01, 32'd102});

    // T2: simultaneous rises produce one word
    do_reset();
    run_to(10);
    pulse(2'b11);
    run_to(40);
    chk("t2_level", {59'd0, level}, 64'd1);
    chk("t2_mask", {62'd0, ev_data[33:32]}, 64'd3);

    // T3: deadtime filters 5-cycle spaced edges
    do_reset();
    for (int k = 0; k < 12; k++) begin
      run_to(10 + 5 * k);
      pulse(2'b01);
    end
    run_to(90);
    chk("t3_level", {59'd0, level}, 64'd3);
    for (int j = 0; j < 3; j++) begin
      tsv[j] = ev_data[31:0];
      ready = 1'b1;
      tick();
      ready = 1'b0;
    end
    chk("t3_first", {32'd0, tsv[0]}, 64'd12);
    chk("t3_gap1", {32'd0, tsv[1] - tsv[0]}, 64'd20);
    chk("t3_gap2", {32'd0, tsv[2] - tsv[1]}, 64'd20);

    // T4: overflow, drops counted per word, ordered drain
    do_reset();
    for (int k = 0; k < 20; k++) begin
      run_to(10 + 20 * k);
      pulse(2'b01);
    end
    run_to(420);
    chk("t4_level_full", {59'd0, level}, 64'd16);
    chk("t4_drops", {48'd0, drops}, 64'd4);
    ready = 1'b1;
    for (int j = 0; j < 16; j++) begin
      chk("t4_order", {32'd0, ev_data[31:0]}, 64'(12 + 20 * j));
      tick();
    end
    ready = 1'b0;
    chk("t4_level_empty", {59'd0, level}, 64'd0);

    // T5: simultaneous push/pop at level 8, then mid-run reset
    base = cyc + 4;
    for (int k = 0; k < 8; k++) begin
      run_to(base + 20 * k);
      pulse(2'b01);
    end
    run_to(base + 198);
    pulse(2'b01);
    tick();
    chk("t5_level_pre", {59'd0, level}, 64'd8);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("t5_level_same", {59'd0, level}, 64'd8);
    chk("t5_head", {32'd0, ev_data[31:0]}, 64'(base + 22));
    chk("t5_drops_kept", {48'd0, drops}, 64'd4);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t5_rst_valid", {63'd0, ev_valid}, 64'd0);
    chk("t5_rst_level", {59'd0, level}, 64'd0);
    chk("t5_rst_drops", {48'd0, drops}, 64'd0);

    // T6: 8-bit timestamp wrap keeps order
    do_reset();
    run_to(253);
    pulse(2'b01);
    run_to(257);
    pulse(2'b10);
    run_to(265);
    chk("t6_first", {54'd0, ev_data8}, {54'd0, 2'b01, 8'hFF});
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("t6_second", {54'd0, ev_data8}, {54'd0, 2'b10, 8'h03});

    // Random traffic against the model, with occasional resets
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(0, 99) < 20) pin[i] = ~pin[i];
      end
      en    = ($urandom_range(0, 9) != 0);
      ready = (n < 2000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 999) != 0);
      tick();
    end
    rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
